// File: rtl/proc_pkg.sv
// Shared processor-subsystem constants and the core-id type used by the
// memory-port arbiters.
package proc_pkg;

  localparam int NUM_CORES = 4;
  localparam int IM_ADDR_W = 8;
  localparam int IM_DATA_W = 16;
  localparam int DM_ADDR_W = 8;

  typedef logic [$clog2(NUM_CORES)-1:0] core_id_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of eff_req at or above
// rr_ptr, wrapping modulo N. Shared by instruction- and data-memory arbiters.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   eff_req,
  input  logic [IDW-1:0] rr_ptr,
  output logic [IDW-1:0] winner,
  output logic           valid
);

  logic [IDW-1:0] cur;

  // Walk N slots from rr_ptr with an explicit wrap so non-power-of-two N works.
  always_comb begin
    cur    = rr_ptr;
    winner = '0;
    valid  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && eff_req[cur]) begin
        winner = cur;
        valid  = 1'b1;
      end
      cur = (cur == IDW'(N - 1)) ? '0 : cur + IDW'(1);
    end
  end

endmodule

// File: rtl/im_wr_arbiter.sv
// Round-robin arbiter sharing the instruction-memory write port among cores.
// Optional per-core grant counters are enabled with IM_WR_ARB_STATS_EN.
module im_wr_arbiter
  import proc_pkg::*;
#(
  parameter int NUM_CORES = proc_pkg::NUM_CORES,
  parameter int ADDR_W    = IM_ADDR_W,
  parameter int DATA_W    = IM_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  input  logic [NUM_CORES*DATA_W-1:0] req_data,
  output logic [NUM_CORES-1:0]        gnt,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        busy
`ifdef IM_WR_ARB_STATS_EN
  ,
  input  logic                        stats_clr,
  output logic [NUM_CORES*16-1:0]     wr_count
`endif
);

  localparam int IDW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0] gnt_q, gnt_d, eff_req;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]       winner;
  logic                 win_valid;

  // A core is masked during its own grant cycle so a held req cannot win twice.
  assign eff_req = req & ~gnt_q;
  assign busy    = |eff_req;

  rr_pick #(.N(NUM_CORES), .IDW(IDW)) u_pick (
    .eff_req (eff_req),
    .rr_ptr  (rr_ptr_q),
    .winner  (winner),
    .valid   (win_valid)
  );

  always_comb begin
    gnt_d       = '0;
    mem_we_d    = win_valid;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rr_ptr_d    = rr_ptr_q;
    if (win_valid) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (winner == IDW'(i)) begin
          gnt_d[i]    = 1'b1;
          mem_addr_d  = req_addr[i*ADDR_W +: ADDR_W];
          mem_wdata_d = req_data[i*DATA_W +: DATA_W];
        end
      end
      rr_ptr_d = (winner == IDW'(NUM_CORES - 1)) ? '0 : winner + IDW'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      gnt_q       <= gnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef IM_WR_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_CORES];

  // Saturating grant counters; clear wins over increment.
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[gi] <= 16'h0000;
      end else if (stats_clr) begin
        cnt_q[gi] <= 16'h0000;
      end else if (gnt_q[gi] && (cnt_q[gi] != 16'hFFFF)) begin
        cnt_q[gi] <= cnt_q[gi] + 16'h0001;
      end else begin
        cnt_q[gi] <= cnt_q[gi];
      end
    end
    assign wr_count[gi*16 +: 16] = cnt_q[gi];
  end
`endif

endmodule
